// File: rtl/gzip_out_framer.sv
`timescale 1ns/1ps
// gzip_out_framer
//   Reads 32-bit words from the Deflate core's output FIFO (non-FWFT, data
//   one cycle after fifo_rden), removes the zero padding the core adds to
//   reach a 64-bit multiple, and emits a byte-exact AXI-Stream. The last
//   beat carries tkeep. A one-word hold register delays every word by one
//   return, so a final word made only of padding can be dropped and tlast
//   moved onto the word before it.
//
// Ports
//   core_clock      single clock
//   bus_reset       synchronous, active-high reset
//   fifo_empty      core output FIFO empty
//   fifo_rden       core FIFO read strobe
//   fifo_data       core FIFO word, stream byte 0 in [7:0]
//   fifo_last       word is the final word of the stream
//   stream_bits     stream length in bits, stable before the last word
//   m_axis_*        AXI-Stream master (tdata/tkeep/tvalid/tready/tlast)
//   words_sent      beats accepted downstream since reset (wraps)
//   pad_dropped     pulse when a padding-only final word is discarded
module gzip_out_framer #(
  parameter int unsigned OUT_DEPTH     = 8,
  parameter int unsigned OUT_DEPTH_LOG = 3
) (
  input  logic        core_clock,
  input  logic        bus_reset,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  input  logic [31:0] fifo_data,
  input  logic        fifo_last,
  input  logic [31:0] stream_bits,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] words_sent,
  output logic        pad_dropped
);

  localparam int unsigned OCC_W = OUT_DEPTH_LOG + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t                    mem [OUT_DEPTH];
  logic [OUT_DEPTH_LOG-1:0] rptr;
  logic [OUT_DEPTH_LOG-1:0] wptr;
  logic [OCC_W-1:0]         occ;
  logic [OCC_W:0]           occ_sum;

  logic        inflight;
  logic [31:0] widx;
  logic [31:0] widx_n;
  logic        hold_valid;
  logic        hold_valid_n;
  logic [31:0] hold_data;
  logic [31:0] hold_data_n;

  logic [32:0]        nbytes;
  logic signed [34:0] rem;
  logic               ret;
  logic               pop;
  logic [1:0]         npush;
  beat_t              e0;
  beat_t              e1;
  beat_t              hold_beat;
  beat_t              head;

  // Bytes-valid mask for a word with v stream bytes left (v clipped to 0..4).
  function automatic logic [3:0] therm(input logic signed [34:0] v);
    if (v >= 4)       therm = 4'b1111;
    else if (v == 3)  therm = 4'b0111;
    else if (v == 2)  therm = 4'b0011;
    else if (v == 1)  therm = 4'b0001;
    else              therm = 4'b0000;
  endfunction

  // An in-flight read may land two pushes (hold + final word), so each
  // outstanding read reserves two slots.
  always_comb begin
    fifo_rden = !bus_reset && !fifo_empty &&
                ((32'(occ) + (inflight ? 32'd2 : 32'd0)) <= (OUT_DEPTH - 32'd2));
  end

  always_comb begin
    nbytes = ({1'b0, stream_bits} + 33'd7) >> 3;
    rem    = $signed({2'b00, nbytes}) - $signed({1'b0, widx, 2'b00});
  end

  always_comb begin
    ret          = inflight && !bus_reset;
    npush        = 2'd0;
    e0           = '0;
    e1           = '0;
    hold_beat    = {hold_data, 4'b1111, 1'b0};
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    widx_n       = widx;
    pad_dropped  = 1'b0;
    if (ret) begin
      if (!fifo_last) begin
        if (hold_valid) begin
          e0    = hold_beat;
          npush = 2'd1;
        end
        hold_valid_n = 1'b1;
        hold_data_n  = fifo_data;
        widx_n       = widx + 32'd1;
      end else begin
        hold_valid_n = 1'b0;
        widx_n       = '0;
        if (rem >= 1) begin
          if (hold_valid) begin
            e0    = hold_beat;
            e1    = {fifo_data, therm(rem), 1'b1};
            npush = 2'd2;
          end else begin
            e0    = {fifo_data, therm(rem), 1'b1};
            npush = 2'd1;
          end
        end else begin
          // Final word is pure padding: the held word becomes the last beat.
          pad_dropped = 1'b1;
          if (hold_valid) begin
            e0    = {hold_data, therm(rem + 35'sd4), 1'b1};
            npush = 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    head          = mem[rptr];
    m_axis_tvalid = (occ != '0);
    m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    m_axis_tkeep  = m_axis_tvalid ? head.keep : '1;
    m_axis_tlast  = m_axis_tvalid && head.last;
    pop           = m_axis_tvalid && m_axis_tready;
    occ_sum       = {1'b0, occ} + (OCC_W + 1)'(npush) - (OCC_W + 1)'(pop);
  end

  always_ff @(posedge core_clock) begin
    if (bus_reset) begin
      rptr       <= '0;
      wptr       <= '0;
      occ        <= '0;
      inflight   <= 1'b0;
      widx       <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      words_sent <= '0;
    end else begin
      assert (occ_sum <= (OCC_W + 1)'(OUT_DEPTH));
      inflight   <= fifo_rden;
      widx       <= widx_n;
      hold_valid <= hold_valid_n;
      hold_data  <= hold_data_n;
      occ        <= occ_sum[OCC_W-1:0];
      wptr       <= wptr + OUT_DEPTH_LOG'(npush);
      if (pop) begin
        rptr       <= rptr + OUT_DEPTH_LOG'(1);
        words_sent <= words_sent + 32'd1;
      end
    end
  end

  always_ff @(posedge core_clock) begin
    if (!bus_reset) begin
      if (npush != 2'd0) mem[wptr] <= e0;
      if (npush == 2'd2) mem[wptr + OUT_DEPTH_LOG'(1)] <= e1;
    end
  end

endmodule

// File: tb/tb_gzip_out_framer.sv
`timescale 1ns/1ps
module tb_gzip_out_framer;

  logic        core_clock;
  logic        bus_reset;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [31:0] fifo_data;
  logic        fifo_last;
  logic [31:0] stream_bits;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] words_sent;
  logic        pad_dropped;

  gzip_out_framer #(.OUT_DEPTH(8), .OUT_DEPTH_LOG(3)) dut (
    .core_clock    (core_clock),
    .bus_reset     (bus_reset),
    .fifo_empty    (fifo_empty),
    .fifo_rden     (fifo_rden),
    .fifo_data     (fifo_data),
    .fifo_last     (fifo_last),
    .stream_bits   (stream_bits),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .words_sent    (words_sent),
    .pad_dropped   (pad_dropped)
  );

  initial begin
    core_clock = 1'b0;
    forever #5 core_clock = ~core_clock;
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // core FIFO contents
  logic [31:0] cq_d[$];
  logic        cq_l[$];
  logic        rd_pend = 1'b0;

  // observed / expected beats
  logic [31:0] obs_d[$];
  logic [3:0]  obs_k[$];
  logic        obs_l[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_k[$];
  logic        exp_l[$];

  int unsigned cyc     = 0;
  int unsigned rmode   = 0;  // 0: ready, 1: 1,0,0,1 pattern, 2: not ready
  int unsigned run     = 0;
  int unsigned max_run = 0;
  int unsigned pad_cnt = 0;
  logic [31:0] exp_ws  = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;
  logic        prev_l;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge core_clock);
    #1;
    if (rd_pend && cq_d.size() > 0) begin
      fifo_data = cq_d.pop_front();
      fifo_last = cq_l.pop_front();
    end
    fifo_empty = (cq_d.size() == 0);
    cyc++;
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_axis_tready = 1'b0;
    endcase
    @(negedge core_clock);
    if (!bus_reset) begin
      if (prev_stall) begin
        check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("stall_tdata", m_axis_tdata, prev_d);
        check("stall_tkeep", 32'(m_axis_tkeep), 32'(prev_k));
        check("stall_tlast", 32'(m_axis_tlast), 32'(prev_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        obs_d.push_back(m_axis_tdata);
        obs_k.push_back(m_axis_tkeep);
        obs_l.push_back(m_axis_tlast);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_k = m_axis_tkeep;
      prev_l = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
    if (fifo_rden) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (pad_dropped) pad_cnt++;
    rd_pend = fifo_rden;
  endtask

  task automatic load_stream(input logic [31:0] bits, input int unsigned n, input logic [31:0] base);
    stream_bits = bits;
    max_run = 0;
    pad_cnt = 0;
    for (int unsigned i = 0; i < n; i++) begin
      cq_d.push_back(base + i);
      cq_l.push_back(i == n - 1);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_d.push_back(d);
    exp_k.push_back(k);
    exp_l.push_back(l);
    exp_ws = exp_ws + 32'd1;
  endtask

  task automatic drain_and_compare(input string name, input int unsigned budget);
    for (int unsigned i = 0; i < budget && obs_d.size() < exp_d.size(); i++) tick();
    repeat (4) tick();
    check({name, "_beats"}, obs_d.size(), exp_d.size());
    for (int unsigned i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      check($sformatf("%s_tdata%0d", name, i), obs_d[i], exp_d[i]);
      check($sformatf("%s_tkeep%0d", name, i), 32'(obs_k[i]), 32'(exp_k[i]));
      check($sformatf("%s_tlast%0d", name, i), 32'(obs_l[i]), 32'(exp_l[i]));
    end
    check({name, "_words_sent"}, words_sent, exp_ws);
    obs_d.delete(); obs_k.delete(); obs_l.delete();
    exp_d.delete(); exp_k.delete(); exp_l.delete();
  endtask

  initial begin
    bus_reset     = 1'b1;
    fifo_empty    = 1'b1;
    fifo_data     = '0;
    fifo_last     = 1'b0;
    stream_bits   = '0;
    m_axis_tready = 1'b1;

    repeat (3) tick();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tkeep", 32'(m_axis_tkeep), 32'hF);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_words_sent", words_sent, 32'd0);
    check("rst_pad", 32'(pad_dropped), 32'd0);
    check("rst_rden", 32'(fifo_rden), 32'd0);
    bus_reset = 1'b0;
    tick();

    // 72 bits: 9 bytes, last core word is pure padding
    rmode = 0;
    load_stream(32'd72, 4, 32'hA100_0000);
    expect_beat(32'hA100_0000, 4'b1111, 1'b0);
    expect_beat(32'hA100_0001, 4'b1111, 1'b0);
    expect_beat(32'hA100_0002, 4'b0001, 1'b1);
    drain_and_compare("s72", 100);
    check("s72_pad", pad_cnt, 32'd1);

    // 128 bits: exact fit
    load_stream(32'd128, 4, 32'hB200_0000);
    expect_beat(32'hB200_0000, 4'b1111, 1'b0);
    expect_beat(32'hB200_0001, 4'b1111, 1'b0);
    expect_beat(32'hB200_0002, 4'b1111, 1'b0);
    expect_beat(32'hB200_0003, 4'b1111, 1'b1);
    drain_and_compare("s128", 100);
    check("s128_pad", pad_cnt, 32'd0);
    check("s128_rden_run", max_run, 32'd4);

    // 100 bits: 13 bytes, one byte in the last word
    load_stream(32'd100, 4, 32'hC300_0000);
    expect_beat(32'hC300_0000, 4'b1111, 1'b0);
    expect_beat(32'hC300_0001, 4'b1111, 1'b0);
    expect_beat(32'hC300_0002, 4'b1111, 1'b0);
    expect_beat(32'hC300_0003, 4'b0001, 1'b1);
    drain_and_compare("s100", 100);
    check("s100_pad", pad_cnt, 32'd0);

    // 16 words under backpressure
    rmode = 1;
    load_stream(32'd512, 16, 32'hD400_0000);
    for (int unsigned i = 0; i < 16; i++)
      expect_beat(32'hD400_0000 + i, 4'b1111, i == 15);
    drain_and_compare("bp16", 300);
    check("bp16_pad", pad_cnt, 32'd0);

    // two short streams in succession
    rmode = 0;
    load_stream(32'd56, 2, 32'hE500_0000);
    expect_beat(32'hE500_0000, 4'b1111, 1'b0);
    expect_beat(32'hE500_0001, 4'b0111, 1'b1);
    drain_and_compare("s56", 100);
    load_stream(32'd40, 2, 32'hF600_0000);
    expect_beat(32'hF600_0000, 4'b1111, 1'b0);
    expect_beat(32'hF600_0001, 4'b0001, 1'b1);
    drain_and_compare("s40", 100);

    // reset with a read in flight and three beats queued
    rmode = 2;
    load_stream(32'd256, 6, 32'h7700_0000);
    repeat (6) tick();
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pre_rst_words_sent", words_sent, exp_ws);
    bus_reset = 1'b1;
    rd_pend = 1'b0;
    cq_d.delete();
    cq_l.delete();
    #1;
    check("rst_mid_rden", 32'(fifo_rden), 32'd0);
    tick();
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_words_sent", words_sent, 32'd0);
    check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("mid_rst_tkeep", 32'(m_axis_tkeep), 32'hF);
    check("mid_rst_tdata", m_axis_tdata, 32'd0);
    tick();
    bus_reset = 1'b0;
    exp_ws = 0;
    rmode = 0;
    tick();
    check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    load_stream(32'd40, 2, 32'h8800_0000);
    expect_beat(32'h8800_0000, 4'b1111, 1'b0);
    expect_beat(32'h8800_0001, 4'b0001, 1'b1);
    drain_and_compare("after_rst", 100);
    check("after_rst_pad", pad_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
